// File: rtl/math_pwr_acc_64.sv
// Windowed I/Q power integrator: sums I^2+Q^2 over 2^LOG2_LEN accepted samples, holds the last window energy on dout.
// Latency: 3 enabled cycles from the last sample of a window to dout/dout_valid; each ena=0 cycle adds one.
// Backpressure: none; samples presented while ena=0 or clear=1 are dropped, so the upstream block must hold them.
module math_pwr_acc_64 #(
    parameter int DW       = 16,
    parameter int LOG2_LEN = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          clear,
    input  logic          din_valid,
    input  logic [DW-1:0] din_i,
    input  logic [DW-1:0] din_q,
    output logic [63:0]   dout,
    output logic          dout_valid,
    output logic          busy
);

    localparam int SQW = 2*DW - 1;
    localparam int PW  = 2*DW;
    localparam int AW  = 2*DW + LOG2_LEN;

    generate
        if (2*DW + 1 + LOG2_LEN > 64) begin : g_width_check
            $error("math_pwr_acc_64: 2*DW+1+LOG2_LEN must not exceed 64");
        end
    endgenerate

    logic signed [PW-1:0]  i_ext;
    logic signed [PW-1:0]  q_ext;
    logic [SQW-1:0]        i_sq_nxt;
    logic [SQW-1:0]        q_sq_nxt;
    logic [SQW-1:0]        isq;
    logic [SQW-1:0]        qsq;
    logic [PW-1:0]         pwr;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         acc_nxt;
    logic [LOG2_LEN-1:0]   cnt;
    logic                  v1;
    logic                  v2;

    // Square in 2*DW bits so the (-2^(DW-1))^2 corner case is exact; it fits in 2*DW-1 unsigned bits.
    assign i_ext    = PW'($signed(din_i));
    assign q_ext    = PW'($signed(din_q));
    assign i_sq_nxt = SQW'(i_ext * i_ext);
    assign q_sq_nxt = SQW'(q_ext * q_ext);
    assign acc_nxt  = acc + AW'(pwr);
    assign busy     = (cnt != '0) | v1 | v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isq        <= '0;
            qsq        <= '0;
            pwr        <= '0;
            acc        <= '0;
            cnt        <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (clear) begin
                // Restart takes priority over ena and over a same-cycle completion.
                v1  <= 1'b0;
                v2  <= 1'b0;
                cnt <= '0;
                acc <= '0;
            end else if (ena) begin
                isq <= i_sq_nxt;
                qsq <= q_sq_nxt;
                v1  <= din_valid;
                pwr <= PW'(isq) + PW'(qsq);
                v2  <= v1;
                if (v2) begin
                    cnt <= cnt + LOG2_LEN'(1);
                    if (cnt == '1) begin
                        dout       <= 64'(acc_nxt);
                        acc        <= '0;
                        dout_valid <= 1'b1;
                    end else begin
                        acc <= acc_nxt;
                    end
                end
            end
        end
    end

endmodule
